// File: rtl/lz77_arith_pkg.sv
// Arithmetic types shared by the LZ77 divider and its inverse recombiner.
package lz77_arith_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 7;

    // Width of an iteration counter that must reach w-1; never narrower than 1 bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/quyu_recombine.sv
// Rebuilds a = q*b + r with a bit-serial shift-add multiplier seeded with r,
// one quotient bit per cycle, fixed latency of WIDTH cycles.
module quyu_recombine
    import lz77_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     r,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result,
    output logic                 div0,
    output logic                 rem_err
);

    localparam int CW = cnt_width(WIDTH);
    localparam int AW = 2 * WIDTH;

    state_t          state;
    state_t          state_nxt;
    logic [WIDTH-1:0] q_r;
    logic [AW-1:0]   b_r;
    logic [AW-1:0]   acc;
    logic [AW-1:0]   acc_sum;
    logic [CW-1:0]   cnt;
    logic            last;

    assign last    = (cnt == CW'(WIDTH - 1));
    // Accumulator is seeded with r, so the final sum is q*b + r without a separate add.
    assign acc_sum = q_r[0] ? (acc + b_r) : acc;

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            cnt     <= '0;
            result  <= '0;
            div0    <= 1'b0;
            rem_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        q_r     <= q;
                        b_r     <= {{WIDTH{1'b0}}, b};
                        acc     <= {{WIDTH{1'b0}}, r};
                        cnt     <= '0;
                        div0    <= (b == '0);
                        rem_err <= (r >= b);
                    end
                end
                RUN: begin
                    acc <= acc_sum;
                    q_r <= q_r >> 1;
                    b_r <= b_r << 1;
                    cnt <= cnt + CW'(1);
                    if (last) result <= acc_sum;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_quyu_recombine.sv
// Scoreboard bench for quyu_recombine: driver predicts q*b+r per accepted start,
// a negedge monitor checks every done pulse and the held outputs in between.
module tb_quyu_recombine;

    localparam int W = 7;

    typedef struct {
        logic [2*W-1:0] res;
        logic           d0;
        logic           re;
        int             done_cyc;
    } exp_t;

    logic           clk;
    logic           rst;
    logic           start;
    logic [W-1:0]   q;
    logic [W-1:0]   b;
    logic [W-1:0]   r;
    logic           busy;
    logic           done;
    logic [2*W-1:0] result;
    logic           div0;
    logic           rem_err;

    quyu_recombine #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .q       (q),
        .b       (b),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .div0    (div0),
        .rem_err (rem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    exp_t           sbq[$];
    int             rem = 0;
    int             cyc = 0;
    logic [2*W-1:0] m_res = '0;
    logic [2*W-1:0] pend = '0;
    logic           m_d0 = 1'b0;
    logic           m_re = 1'b0;
    bit             mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // One clock edge: the reference model consumes the inputs sampled at this edge.
    task automatic step();
        exp_t e;
        @(posedge clk);
        if (rst) begin
            rem   = 0;
            m_res = '0;
            m_d0  = 1'b0;
            m_re  = 1'b0;
            sbq.delete();
        end else if (rem == 0) begin
            if (start) begin
                e.res      = (2*W)'(int'(q) * int'(b) + int'(r));
                e.d0       = (b == 0);
                e.re       = (r >= b);
                e.done_cyc = cyc + W + 1;
                sbq.push_back(e);
                pend = e.res;
                m_d0 = e.d0;
                m_re = e.re;
                rem  = W + 1;
            end
        end else begin
            rem--;
            if (rem == 1) m_res = pend;
        end
        cyc++;
        #1;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (rem != 0 && n < 40) begin
            step();
            n++;
        end
        checks++;
        if (rem != 0) begin
            errors++;
            $display("FAIL wait_idle: still busy after %0d cycles", n);
        end
    endtask

    task automatic run_op(input logic [W-1:0] qv, input logic [W-1:0] bv, input logic [W-1:0] rv);
        start = 1'b1;
        q = qv;
        b = bv;
        r = rv;
        step();
        start = 1'b0;
        q = W'($urandom);
        b = W'($urandom);
        r = W'($urandom);
        wait_idle();
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            chk("busy", busy, (rem != 0));
            if (done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    e = sbq.pop_front();
                    chk("done_result", result, e.res);
                    chk("done_div0", div0, e.d0);
                    chk("done_rem_err", rem_err, e.re);
                    chk("done_latency", cyc, e.done_cyc);
                end
            end else begin
                chk("result_hold", result, m_res);
                if (sbq.size() != 0 && cyc > sbq[0].done_cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL missing_done: got done=0 expected done=1 at cycle %0d", sbq[0].done_cyc);
                    void'(sbq.pop_front());
                end
            end
            chk("div0_hold", div0, m_d0);
            chk("rem_err_hold", rem_err, m_re);
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        q     = '0;
        b     = '0;
        r     = '0;
        step();
        mon_en = 1'b1;
        step();
        rst = 1'b0;

        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_div0", div0, 0);
        chk("rst_rem_err", rem_err, 0);

        run_op(7'd5, 7'd9, 7'd3);
        chk("lit_5_9_3", result, 48);
        chk("lit_5_9_3_flags", {div0, rem_err}, 0);
        run_op(7'd127, 7'd127, 7'd126);
        chk("lit_max", result, 16255);
        chk("lit_max_flags", {div0, rem_err}, 0);
        run_op(7'd10, 7'd0, 7'd4);
        chk("lit_div0", result, 4);
        chk("lit_div0_flags", {div0, rem_err}, 2'b11);
        run_op(7'd2, 7'd5, 7'd5);
        chk("lit_rem_eq", result, 15);
        chk("lit_rem_eq_flags", {div0, rem_err}, 2'b01);
        run_op(7'd14, 7'd7, 7'd2);
        chk("lit_divider_roundtrip", result, 100);
        run_op(7'd0, 7'd99, 7'd17);
        chk("lit_q0", result, 17);

        // start held high: ops chain back to back, starts while busy are ignored
        start = 1'b1;
        for (int i = 0; i < 40; i++) begin
            q = W'($urandom);
            b = W'($urandom);
            r = W'($urandom);
            step();
        end
        start = 1'b0;
        wait_idle();

        // reset three RUN edges into an operation
        start = 1'b1;
        q = 7'd100;
        b = 7'd100;
        r = 7'd50;
        step();
        start = 1'b0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrun_rst_busy", busy, 0);
        chk("midrun_rst_result", result, 0);
        repeat (10) step();
        run_op(7'd3, 7'd4, 7'd1);
        chk("after_rst_op", result, 13);

        for (int i = 0; i < 600; i++) begin
            start = ($urandom_range(0, 2) == 0);
            rst   = ($urandom_range(0, 59) == 0);
            q = W'($urandom);
            b = W'($urandom);
            r = W'($urandom);
            step();
        end
        start = 1'b0;
        rst   = 1'b0;
        wait_idle();
        repeat (3) step();
        chk("scoreboard_empty", sbq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
